// File: rtl/enable_monitor.sv
// enable_monitor: receive-side health checker for periodic single-cycle enable strobes.
// Measures the clk-cycle interval between strobes, declares lock after a run of
// in-tolerance periods, and flags early strobes (err_fast) and missing strobes (err_slow).
//
// Ports:
//   clk          - system clock
//   rst          - synchronous, active-high reset
//   enable_in    - strobe under test, sampled every clk
//   clear_errors - synchronous clear of err_count (wins over a same-cycle increment)
//   period_valid - one-cycle pulse, period holds a new measurement
//   period       - last measured interval in cycles
//   locked       - high while in LOCKED
//   err_fast     - one-cycle pulse, strobe arrived early
//   err_slow     - one-cycle pulse, strobe missing (timeout)
//   err_count    - saturating count of err_fast plus err_slow events
module enable_monitor #(
    parameter int unsigned clk_frequency_p = 100_000_000,
    parameter int unsigned ena_frequency_p = 1_000_000,
    parameter int unsigned tolerance_p     = 1,
    parameter int unsigned lock_count_p    = 4,
    localparam int unsigned NOM_N          = clk_frequency_p / ena_frequency_p,
    localparam int unsigned CNT_W          = $clog2(NOM_N + tolerance_p + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_in,
    input  logic             clear_errors,
    output logic             period_valid,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             err_fast,
    output logic             err_slow,
    output logic [7:0]       err_count
);

    localparam int unsigned GOOD_W = $clog2(lock_count_p + 1);
    localparam logic [CNT_W-1:0]  CNT_LO    = CNT_W'(NOM_N - tolerance_p);
    localparam logic [CNT_W-1:0]  CNT_HI    = CNT_W'(NOM_N + tolerance_p);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(lock_count_p - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [GOOD_W-1:0]   r_good;
    logic [GOOD_W-1:0]   w_good_nxt;
    logic                w_period_valid;
    logic                w_err_fast;
    logic                w_err_slow;
    logic                w_early;

    // State, interval counter and good-period counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_good  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_good  <= w_good_nxt;
        end
    end

    // Next-state, counter and event decode
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_good_nxt     = r_good;
        w_period_valid = 1'b0;
        w_err_fast     = 1'b0;
        w_err_slow     = 1'b0;
        w_early        = (r_cnt < CNT_LO);

        case (r_state)
            IDLE: begin
                // First strobe has no reference: just start measuring
                if (enable_in) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_good_nxt  = '0;
                    w_state_nxt = ACQUIRE;
                end
            end

            ACQUIRE, LOCKED: begin
                if (enable_in) begin
                    // A strobe at exactly CNT_HI is in range, so it is checked before the timeout
                    w_cnt_nxt      = CNT_W'(1);
                    w_period_valid = 1'b1;
                    if (w_early) begin
                        w_err_fast  = 1'b1;
                        w_good_nxt  = '0;
                        w_state_nxt = ACQUIRE;
                    end else if (r_state == ACQUIRE) begin
                        if (r_good == GOOD_LAST) begin
                            w_good_nxt  = '0;
                            w_state_nxt = LOCKED;
                        end else begin
                            w_good_nxt = r_good + GOOD_W'(1);
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_HI) begin
                        w_err_slow  = 1'b1;
                        w_good_nxt  = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_good_nxt  = '0;
            end
        endcase
    end

    // Registered outputs, one cycle after the sampling cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            period_valid <= 1'b0;
            period       <= '0;
            locked       <= 1'b0;
            err_fast     <= 1'b0;
            err_slow     <= 1'b0;
            err_count    <= '0;
        end else begin
            period_valid <= w_period_valid;
            err_fast     <= w_err_fast;
            err_slow     <= w_err_slow;
            locked       <= (w_state_nxt == LOCKED);
            if (w_period_valid) begin
                period <= r_cnt;
            end
            if (clear_errors) begin
                err_count <= '0;
            end else if ((w_err_fast || w_err_slow) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_enable_monitor.sv
// tb_enable_monitor: checks enable_monitor (N=10, tolerance 1, lock count 4) with an
// interval table, hand-written corner sequences and randomized strobes, all compared
// every cycle against a timestamp-based reference model.
module tb_enable_monitor;

    localparam int NOM  = 10;
    localparam int TOL  = 1;
    localparam int LOCK = 4;

    logic       clk;
    logic       rst;
    logic       enable_in;
    logic       clear_errors;
    logic       period_valid;
    logic [3:0] period;
    logic       locked;
    logic       err_fast;
    logic       err_slow;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: timestamps of strobes rather than a counter/state machine
    int t       = 0;
    int last_t  = 0;
    bit has_ref = 0;
    int good    = 0;
    bit m_lk    = 0;
    bit m_pv    = 0;
    int m_per   = 0;
    bit m_ef    = 0;
    bit m_es    = 0;
    int m_ec    = 0;

    enable_monitor #(
        .clk_frequency_p(100),
        .ena_frequency_p(10),
        .tolerance_p    (1),
        .lock_count_p   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_in   (enable_in),
        .clear_errors(clear_errors),
        .period_valid(period_valid),
        .period      (period),
        .locked      (locked),
        .err_fast    (err_fast),
        .err_slow    (err_slow),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", nm, t, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs after the edge
    task automatic step(input bit e, input bit clr, input bit r);
        int iv;
        bit ev;
        enable_in    = e;
        clear_errors = clr;
        rst          = r;
        @(posedge clk);
        ev = 0;
        if (r) begin
            has_ref = 0; good = 0; m_lk = 0; m_pv = 0; m_per = 0;
            m_ef = 0; m_es = 0; m_ec = 0;
        end else begin
            m_pv = 0; m_ef = 0; m_es = 0;
            iv = t - last_t;
            if (e) begin
                if (has_ref) begin
                    m_pv  = 1;
                    m_per = iv;
                    if (iv < NOM - TOL) begin
                        m_ef = 1; m_lk = 0; good = 0;
                    end else if (!m_lk) begin
                        good++;
                        if (good == LOCK) begin
                            m_lk = 1; good = 0;
                        end
                    end
                end
                has_ref = 1;
                last_t  = t;
            end else if (has_ref && iv == NOM + TOL) begin
                m_es = 1; m_lk = 0; has_ref = 0; good = 0;
            end
            ev = m_ef | m_es;
            if (clr) m_ec = 0;
            else if (ev && m_ec < 255) m_ec++;
        end
        t++;
        #1;
        chk("period_valid", int'(period_valid), int'(m_pv));
        chk("period", int'(period), m_per);
        chk("locked", int'(locked), int'(m_lk));
        chk("err_fast", int'(err_fast), int'(m_ef));
        chk("err_slow", int'(err_slow), int'(m_es));
        chk("err_count", int'(err_count), m_ec);
        chk("err_exclusive", int'(err_fast & err_slow), 0);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        int gap;
        bit pv;
        int per;
        bit lk;
        bit ef;
        int ec;
    } vec_t;

    vec_t tbl[15];

    initial begin
        enable_in = 0; clear_errors = 0; rst = 1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("reset_locked", int'(locked), 0);
        chk("reset_period", int'(period), 0);
        chk("reset_err_count", int'(err_count), 0);

        // Regular strobes, lock, early strobe and relock, tolerance-edge intervals
        tbl[0]  = '{3,  0, 0,  0, 0, 0};
        tbl[1]  = '{10, 1, 10, 0, 0, 0};
        tbl[2]  = '{10, 1, 10, 0, 0, 0};
        tbl[3]  = '{10, 1, 10, 0, 0, 0};
        tbl[4]  = '{10, 1, 10, 1, 0, 0};
        tbl[5]  = '{10, 1, 10, 1, 0, 0};
        tbl[6]  = '{8,  1, 8,  0, 1, 1};
        tbl[7]  = '{10, 1, 10, 0, 0, 1};
        tbl[8]  = '{10, 1, 10, 0, 0, 1};
        tbl[9]  = '{10, 1, 10, 0, 0, 1};
        tbl[10] = '{10, 1, 10, 1, 0, 1};
        tbl[11] = '{9,  1, 9,  1, 0, 1};
        tbl[12] = '{11, 1, 11, 1, 0, 1};
        tbl[13] = '{9,  1, 9,  1, 0, 1};
        tbl[14] = '{11, 1, 11, 1, 0, 1};
        for (int k = 0; k < 15; k++) begin
            quiet(tbl[k].gap - 1);
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_pv", k), int'(period_valid), int'(tbl[k].pv));
            if (tbl[k].pv) chk($sformatf("tbl%0d_period", k), int'(period), tbl[k].per);
            chk($sformatf("tbl%0d_locked", k), int'(locked), int'(tbl[k].lk));
            chk($sformatf("tbl%0d_err_fast", k), int'(err_fast), int'(tbl[k].ef));
            chk($sformatf("tbl%0d_err_slow", k), int'(err_slow), 0);
            chk($sformatf("tbl%0d_err_count", k), int'(err_count), tbl[k].ec);
        end

        // Strobes stop while locked: single err_slow after cnt reaches 11
        quiet(10);
        chk("stop_no_early_slow", int'(err_slow), 0);
        quiet(1);
        chk("stop_err_slow", int'(err_slow), 1);
        chk("stop_locked", int'(locked), 0);
        chk("stop_err_count", int'(err_count), 2);
        quiet(1);
        chk("stop_slow_once", int'(err_slow), 0);
        quiet(3);
        step(1'b1, 1'b0, 1'b0);
        chk("restart_no_pv", int'(period_valid), 0);
        quiet(9);
        step(1'b1, 1'b0, 1'b0);
        chk("restart_pv", int'(period_valid), 1);
        chk("restart_period", int'(period), 10);

        // Interval 12: timeout fires first, strobe is a fresh first strobe
        quiet(11);
        chk("gap12_err_slow", int'(err_slow), 1);
        chk("gap12_err_count", int'(err_count), 3);
        step(1'b1, 1'b0, 1'b0);
        chk("gap12_no_pv", int'(period_valid), 0);
        chk("gap12_no_fast", int'(err_fast), 0);

        // Relock, then reset mid-lock
        for (int k = 0; k < 4; k++) begin
            quiet(9);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("relock", int'(locked), 1);
        quiet(3);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_pv", int'(period_valid), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_count", int'(err_count), 0);

        // Continuous enable: saturation and clear priority
        for (int k = 0; k < 300; k++) step(1'b1, 1'b0, 1'b0);
        chk("sat_255", int'(err_count), 255);
        chk("cont_fast", int'(err_fast), 1);
        chk("cont_period", int'(period), 1);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0);
        chk("sat_hold", int'(err_count), 255);
        step(1'b1, 1'b1, 1'b0);
        chk("clear_wins", int'(err_count), 0);
        chk("clear_err_fast", int'(err_fast), 1);

        // Randomized strobe gaps with occasional clears and resets
        for (int k = 0; k < 250; k++) begin
            int gap;
            gap = int'($urandom_range(1, 14));
            for (int i = 0; i < gap - 1; i++)
                step(1'b0, ($urandom_range(0, 29) == 0), ($urandom_range(0, 499) == 0));
            step(1'b1, ($urandom_range(0, 29) == 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enable_monitor.md
Name: enable_monitor

Overview:
- Receive-side checker for periodic single-cycle enable strobes, such as the strobes produced by the team's clock-enable generators.
- Measures the interval between successive strobes in clk cycles and reports each measured period.
- Declares lock after a run of in-tolerance periods, and flags strobes that arrive too early or never arrive.
- Sits next to any strobe-driven consumer as a health monitor; outputs feed status registers or an interrupt.

Parameters:
- clk_frequency_p, 100_000_000, clk frequency in Hz.
- ena_frequency_p, 1_000_000, expected strobe frequency in Hz. Nominal period N = clk_frequency_p / ena_frequency_p (integer division). N >= 2 is required.
- tolerance_p, 1, allowed deviation from N in cycles. 0 <= tolerance_p < N - 1 is required.
- lock_count_p, 4, consecutive in-range periods needed to lock. Must be >= 1.
- Derived localparam CNT_W = $clog2(N + tolerance_p + 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- enable_in  input  1  strobe under test, sampled every clk.
- clear_errors  input  1  synchronous clear of err_count.
- period_valid  output  1  one-cycle pulse; period holds a new measurement.
- period  output  CNT_W  last measured interval in cycles.
- locked  output  1  high while in LOCKED.
- err_fast  output  1  one-cycle pulse; strobe arrived early.
- err_slow  output  1  one-cycle pulse; strobe missing (timeout).
- err_count  output  8  saturating count of err_fast plus err_slow events.

Behaviour:
- Reset is synchronous, active-high, one clock, one reset, fully synchronous design. On reset:
  - state = IDLE, cnt = 0, good_cnt = 0.
  - All outputs are 0, including period and err_count.
- Interval counter cnt (CNT_W bits):
  - On a cycle with enable_in = 1: cnt <= 1.
  - Otherwise in ACQUIRE or LOCKED: cnt <= cnt + 1.
  - Held in IDLE.
  - With strobes every N cycles, cnt == N on the cycle of the next strobe; measured period = cnt on that cycle.
- In-range test: N - tolerance_p <= cnt <= N + tolerance_p.
- States:
  - IDLE: waits for the first strobe, which has no reference, so no period_valid is produced. enable_in → ACQUIRE, good_cnt = 0.
  - ACQUIRE, strobe in range: period_valid, good_cnt++. When good_cnt reaches lock_count_p → LOCKED, good_cnt = 0.
  - ACQUIRE or LOCKED, strobe with cnt < N - tolerance_p: period_valid, err_fast, → ACQUIRE, good_cnt = 0. The strobe becomes the new reference.
  - LOCKED, strobe in range: period_valid, stay in LOCKED.
  - ACQUIRE or LOCKED, enable_in = 0 and cnt == N + tolerance_p: err_slow, → IDLE. No period_valid.
- Simultaneous events:
  - A strobe on the cycle cnt == N + tolerance_p is in range, and the timeout does not fire.
  - err_fast and err_slow are never both asserted.
- Outputs are registered; all responses appear the cycle after the sampling cycle.
  - period updates only together with period_valid and otherwise holds its value.
  - locked is registered from the next state, so it rises together with the period_valid of the lock_count_p-th good period.
- err_count:
  - Increments by 1 on each err_fast or err_slow and saturates at 255.
  - clear_errors sets it to 0; clear wins over a same-cycle increment.
- enable_in held high continuously measures period 1 every cycle. This gives err_fast every cycle, except the first strobe taken from IDLE.
- Reset asserted mid-measurement discards state; the next strobe is treated as a first strobe.

Test Plan:
Configuration for all tests: N=10 (clk 100, ena 10), tolerance_p=1, lock_count_p=4.
1. Strobes every 10 cycles, 6 strobes → no period_valid for strobe 1; period_valid with period=10 one cycle after strobes 2–6; locked rises with the strobe-5 period_valid; no errors; err_count=0.
2. Locked, then a strobe 8 cycles after the previous one → err_fast and period_valid with period=8 on the same cycle; locked falls; err_count=1; relock 4 good periods later.
3. Locked, intervals 9, 11, 9, 11 → all period_valid, no errors, locked stays high.
4. Locked, strobes stop → err_slow exactly once, one cycle after cnt reaches 11; locked low; err_count=1. The next strobe produces no period_valid; the strobe after it (10 cycles later) reports period=10.
5. Boundary cases: interval 11 → in range. Interval 12 → err_slow fires first, and the strobe at 12 is handled as an IDLE first strobe with no period_valid and no err_fast.
6. rst asserted while locked → next cycle all outputs 0. Then force 300 early strobes → err_count=255 and holds. clear_errors on the same cycle as an error → err_count=0.
